// File: rtl/de0_nano_sysid_ext.sv
`default_nettype none
// ============================================================================
// Module   : de0_nano_sysid_ext
// Purpose  : System-ID / uptime slave for the DE0-Nano Avalon-MM data master.
//            Word 0 ID, word 1 build timestamp, words 2/3 a coherent 64-bit
//            view of a free-running uptime counter, word 4 CTRL (FREEZE,
//            CLEAR pulse, sticky OVF), words 5.. byte-enabled scratch.
//            Reads return after a fixed READ_LATENCY; no waitrequest.
// Ports    : clock         - sole clock
//            reset_n       - asynchronous, active-low reset
//            address[2:0]  - word address
//            read / write  - transfer strobes, one transfer per cycle
//            writedata[31:0], byteenable[3:0] - write payload and lanes
//            readdata[31:0], readdatavalid    - read response (data is 0
//                                               whenever valid is low)
// Revision : 1.0 - initial release
// ============================================================================
module de0_nano_sysid_ext #(
   parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP    = 32'd1627626367,
   parameter int          UPTIME_WIDTH = 48,
   parameter int          NUM_SCRATCH  = 2,
   parameter int          READ_LATENCY = 1,
   // Counter value loaded at reset; lets simulation start near the wrap.
   parameter logic [63:0] UPTIME_RESET = 64'd0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   localparam logic [2:0] c_ADDR_ID   = 3'd0;
   localparam logic [2:0] c_ADDR_TS   = 3'd1;
   localparam logic [2:0] c_ADDR_LO   = 3'd2;
   localparam logic [2:0] c_ADDR_HI   = 3'd3;
   localparam logic [2:0] c_ADDR_CTRL = 3'd4;
   localparam logic [2:0] c_ADDR_SCR0 = 3'd5;
   localparam logic [UPTIME_WIDTH-1:0] c_COUNT_ONE = {{(UPTIME_WIDTH-1){1'b0}}, 1'b1};

   logic [UPTIME_WIDTH-1:0] r_count;
   logic [31:0]             r_hi_shadow;
   logic                    r_freeze;
   logic                    r_ovf;
   logic [31:0]             r_scratch [NUM_SCRATCH];
   logic [READ_LATENCY-1:0] r_pipe_valid;
   logic [31:0]             r_pipe_data [READ_LATENCY];

   logic [63:0] w_count64;
   logic        w_ctrl_wr;
   logic        w_clear;
   logic        w_wrap;
   logic [31:0] w_rd_data;

   assign w_count64 = 64'(r_count);

   // CTRL only listens to lane 0; a write without it is a no-op.
   assign w_ctrl_wr = write && (address == c_ADDR_CTRL) && byteenable[0];
   assign w_clear   = w_ctrl_wr && writedata[1];
   // CLEAR outranks the wrap, so a coincident clear never raises OVF.
   assign w_wrap    = !w_clear && !r_freeze && (&r_count);

   // ---------------------------------------------------------------- counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count     <= UPTIME_RESET[UPTIME_WIDTH-1:0];
         r_freeze    <= 1'b0;
         r_ovf       <= 1'b0;
         r_hi_shadow <= '0;
      end else begin
         if (w_clear) begin
            r_count <= '0;
         end else if (!r_freeze) begin
            r_count <= r_count + c_COUNT_ONE;
         end

         // FREEZE uses the old value this cycle, so the write cycle still counts.
         if (w_ctrl_wr) begin
            r_freeze <= writedata[0];
         end

         // Set beats clear when a wrap and a write-1-to-clear coincide.
         if (w_wrap) begin
            r_ovf <= 1'b1;
         end else if (w_ctrl_wr && writedata[2]) begin
            r_ovf <= 1'b0;
         end

         // HI shadow is captured from the same sample the LO read returns.
         if (read && (address == c_ADDR_LO)) begin
            r_hi_shadow <= w_count64[63:32];
         end
      end
   end

   // ---------------------------------------------------------------- scratch
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            r_scratch[i] <= '0;
         end
      end else if (write) begin
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (address == (c_ADDR_SCR0 + 3'(i))) begin
               for (int b = 0; b < 4; b++) begin
                  if (byteenable[b]) begin
                     r_scratch[i][8*b +: 8] <= writedata[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- read mux
   // Sampled from pre-update state, so a same-cycle write is not visible yet.
   always_comb begin
      w_rd_data = '0;
      case (address)
         c_ADDR_ID:   w_rd_data = ID_VALUE;
         c_ADDR_TS:   w_rd_data = TIMESTAMP;
         c_ADDR_LO:   w_rd_data = w_count64[31:0];
         c_ADDR_HI:   w_rd_data = r_hi_shadow;
         c_ADDR_CTRL: w_rd_data = {29'd0, r_ovf, 1'b0, r_freeze};
         default: begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
               if (address == (c_ADDR_SCR0 + 3'(i))) begin
                  w_rd_data = r_scratch[i];
               end
            end
         end
      endcase
   end

   // ---------------------------------------------------------------- response
   // Data is zeroed at entry so the pipe never carries stale data with valid low.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pipe_valid <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_pipe_data[i] <= '0;
         end
      end else begin
         r_pipe_valid[0] <= read;
         r_pipe_data[0]  <= read ? w_rd_data : 32'd0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_pipe_valid[i] <= r_pipe_valid[i-1];
            r_pipe_data[i]  <= r_pipe_data[i-1];
         end
      end
   end

   assign readdatavalid = r_pipe_valid[READ_LATENCY-1];
   assign readdata      = r_pipe_data[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_de0_nano_sysid_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_de0_nano_sysid_ext
// Purpose  : Self-checking bench. Three instances with different latency /
//            width / ID share one stimulus bus; a behavioural model predicts
//            every response slot of every instance, every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_de0_nano_sysid_ext;

   localparam logic [63:0] c_NEAR_WRAP = 64'h1_FFFF_FFC4; // 2^33 - 60

   logic        clock;
   logic        reset_n;
   logic [2:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] rdata  [3];
   logic        rvalid [3];

   int ncmp = 0;
   int nmis = 0;
   int cyc  = 0;

   // Per-instance configuration, mirrored in the instantiations below.
   int          lat   [3] = '{1, 3, 2};
   int          width [3] = '{48, 33, 48};
   logic [31:0] idv   [3] = '{32'hCAFE0001, 32'hCAFE0001, 32'h5EED0002};
   logic [31:0] tsv   [3] = '{32'd1627626367, 32'd1627626367, 32'h0BADF00D};

   // Reference state.
   logic [63:0] m_cnt    [3];
   logic [31:0] m_shadow [3];
   logic [31:0] m_scr    [3][2];
   logic        m_frz    [3];
   logic        m_ovf    [3];
   // Expected response per (instance, cycle mod 8).
   logic        ev [3][8];
   logic [31:0] ed [3][8];

   de0_nano_sysid_ext #(.ID_VALUE(32'hCAFE0001), .UPTIME_WIDTH(48), .NUM_SCRATCH(2),
                        .READ_LATENCY(1)) u_d0 (
      .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable),
      .readdata(rdata[0]), .readdatavalid(rvalid[0]));

   de0_nano_sysid_ext #(.ID_VALUE(32'hCAFE0001), .UPTIME_WIDTH(33), .NUM_SCRATCH(2),
                        .READ_LATENCY(3), .UPTIME_RESET(c_NEAR_WRAP)) u_d1 (
      .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable),
      .readdata(rdata[1]), .readdatavalid(rvalid[1]));

   de0_nano_sysid_ext #(.ID_VALUE(32'h5EED0002), .TIMESTAMP(32'h0BADF00D),
                        .UPTIME_WIDTH(48), .NUM_SCRATCH(2), .READ_LATENCY(2)) u_d2 (
      .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable),
      .readdata(rdata[2]), .readdatavalid(rvalid[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(int d, int a);
      case (a)
         0: return idv[d];
         1: return tsv[d];
         2: return m_cnt[d][31:0];
         3: return m_shadow[d];
         4: return (m_ovf[d] ? 32'd4 : 32'd0) + (m_frz[d] ? 32'd1 : 32'd0);
         5, 6: return m_scr[d][a-5];
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      for (int d = 0; d < 3; d++) begin
         m_cnt[d]    = (d == 1) ? c_NEAR_WRAP : 64'd0;
         m_shadow[d] = 0;
         m_scr[d][0] = 0;
         m_scr[d][1] = 0;
         m_frz[d]    = 0;
         m_ovf[d]    = 0;
         for (int s = 0; s < 8; s++) begin
            ev[d][s] = 0;
            ed[d][s] = 0;
         end
      end
   endtask

   // One bus cycle: apply the rules to the model, advance one edge, check outputs.
   task automatic m_step(int d);
      logic        ctrl_wr;
      logic [63:0] limit;
      int          a;
      a       = int'(address);
      limit   = (64'd1 << width[d]);
      ctrl_wr = write && (a == 4) && byteenable[0];
      if (read && a == 2) m_shadow[d] = 32'(m_cnt[d] / 64'h1_0000_0000);
      if (ctrl_wr && writedata[2]) m_ovf[d] = 0;
      if (ctrl_wr && writedata[1]) begin
         m_cnt[d] = 0;
      end else if (!m_frz[d]) begin
         if (m_cnt[d] + 1 == limit) begin
            m_cnt[d] = 0;
            m_ovf[d] = 1;
         end else begin
            m_cnt[d] = m_cnt[d] + 1;
         end
      end
      if (ctrl_wr) m_frz[d] = writedata[0];
      if (write && (a == 5 || a == 6))
         for (int b = 0; b < 4; b++)
            if (byteenable[b]) m_scr[d][a-5][8*b +: 8] = writedata[8*b +: 8];
   endtask

   task automatic cycle();
      for (int d = 0; d < 3; d++) begin
         if (read) begin
            ev[d][(cyc + lat[d]) % 8] = 1;
            ed[d][(cyc + lat[d]) % 8] = m_read(d, int'(address));
         end
         m_step(d);
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
      read  = 0;
      write = 0;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d valid c%0d", d, cyc), 64'(rvalid[d]), 64'(ev[d][cyc % 8]));
         chk($sformatf("d%0d data c%0d", d, cyc), 64'(rdata[d]),
             ev[d][cyc % 8] ? 64'(ed[d][cyc % 8]) : 64'd0);
         ev[d][cyc % 8] = 0;
      end
   endtask

   task automatic rd(int a);
      read    = 1;
      address = 3'(a);
      cycle();
   endtask

   task automatic wr(int a, logic [31:0] dat, logic [3:0] be);
      write      = 1;
      address    = 3'(a);
      writedata  = dat;
      byteenable = be;
      cycle();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Called at a negedge; checks the asynchronous drop, then holds reset two edges.
   task automatic do_reset();
      reset_n = 0;
      read    = 0;
      write   = 0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d reset valid", d), 64'(rvalid[d]), 64'd0);
         chk($sformatf("d%0d reset data", d), 64'(rdata[d]), 64'd0);
      end
      m_reset();
      repeat (2) @(negedge clock);
      reset_n = 1;
   endtask

   task automatic wait_d1_allones();
      for (int i = 0; i < 300 && m_cnt[1] != (64'd1 << 33) - 1; i++) cycle();
   endtask

   initial begin
      reset_n    = 0;
      read       = 0;
      write      = 0;
      address    = 0;
      writedata  = 0;
      byteenable = 0;
      @(negedge clock);
      do_reset();

      // Uptime at cycle 10, HI without a prior LO, then ID/TS back to back.
      idle(10);
      rd(3);
      rd(2);
      rd(3);
      rd(0);
      rd(1);
      idle(4);

      // Natural wrap of the 33-bit instance with a delayed HI read.
      wait_d1_allones();
      rd(2);
      idle(100);
      rd(3);
      rd(4);
      wr(4, 32'h4, 4'b0001);
      rd(4);
      idle(3);

      // Freeze, hold, then clear with and without freeze kept.
      wr(4, 32'h1, 4'b0001);
      idle(3);
      rd(2);
      rd(2);
      wr(4, 32'h1, 4'b1110);
      rd(2);
      wr(4, 32'h3, 4'b0001);
      rd(2);
      rd(2);
      wr(4, 32'h2, 4'b0001);
      rd(2);
      rd(2);
      rd(4);

      // Scratch byte lanes, unmapped address, same-cycle read/write.
      wr(5, 32'h12345678, 4'hF);
      wr(5, 32'hAAAAAAAA, 4'b0101);
      rd(5);
      wr(7, 32'hFFFFFFFF, 4'hF);
      rd(7);
      read = 1;
      wr(6, 32'h0F0F0F0F, 4'hF);
      rd(6);
      idle(3);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         read       = 1'($urandom_range(0, 1));
         write      = ($urandom_range(0, 3) == 0);
         address    = 3'($urandom_range(0, 7));
         writedata  = $urandom;
         byteenable = 4'($urandom);
         if (address == 3'd4 && $urandom_range(0, 3) != 0) writedata[1:0] = 2'b00;
         cycle();
      end
      idle(4);

      // CLEAR coincident with the wrap: counter 0, OVF stays clear.
      @(negedge clock);
      do_reset();
      wait_d1_allones();
      wr(4, 32'h2, 4'b0001);
      rd(4);
      rd(2);
      idle(4);

      // Reset while responses are in flight, then reset values read back.
      wr(5, 32'hDEADBEEF, 4'hF);
      wr(4, 32'h1, 4'b0001);
      rd(5);
      do_reset();
      idle(5);
      rd(5);
      rd(6);
      rd(4);
      rd(3);
      rd(2);
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end

endmodule
`default_nettype wire
